preg_write_arbiter: RTL and testbench
=====================================

Name: preg_write_arbiter

Overview:
- Shares the single write port of the pointer register file (64 entries, 12-bit lbid plus 16-bit ofs) among three requesters using round-robin arbitration.
- Its outputs drive the register file's we/pw/lbidw/ofsw directly.
- When a grant targets the PC pointer register, it enforces a programmable hold window so that later writes cannot race the resulting PC update.

Parameters:
- PC_REG, 6'h3f, pointer index whose write raises pc_update_req in the register file.
- PC_HOLD_CYCLES, 2, number of cycles grants are blocked after a PC_REG write is issued; 0 disables the hold. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  3  per-requester write request.
- req_ready  output  3  per-requester accept; a transfer occurs when valid and ready are both high at the rising edge.
- req_pw  input  18  packed pointer index; requester i occupies [6i+5:6i].
- req_lbid  input  36  packed lbid; requester i occupies [12i+11:12i].
- req_ofs  input  48  packed ofs; requester i occupies [16i+15:16i].
- we  output  1  registered write enable to the register file.
- pw  output  6  registered write index.
- lbidw  output  12  registered lbid write data.
- ofsw  output  16  registered ofs write data.
- pc_hold  output  1  high while the arbiter is in HOLD.
- last_grant  output  2  index of the most recently granted requester.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on the port named reset.
- Reset values: we=0, pw=0, lbidw=0, ofsw=0, pc_hold=0, last_grant=2, state=ARB, hold counter=0. Reset is effective immediately, without waiting for a clock edge.
- States:
  - ARB: grants are allowed.
  - HOLD: all req_ready outputs are 0.
- Arbitration in ARB:
  - Priority order is (last_grant+1) mod 3, then +2, then +3, all mod 3.
  - The first requester in that order with req_valid=1 wins.
  - req_ready is combinational and one-hot: 1 for the winner only. It is all-zero when no request is valid or when the state is HOLD.
- Requester obligations: a requester holds valid and its payload stable until accepted. The arbiter does not buffer requests and does not drop them.
- Transfer in cycle N:
  - At the edge ending cycle N, the output registers load the winner's payload and set we=1, and last_grant takes the winner index.
  - Write data is therefore presented in cycle N+1, which is 1-cycle latency.
  - The register file commits at the edge ending cycle N+1.
- No transfer in cycle N: we=0 in cycle N+1. pw, lbidw and ofsw hold their previous values.
- Throughput: one write per cycle while not in HOLD.
- PC hazard:
  - If the granted pw equals PC_REG and PC_HOLD_CYCLES>0, the state becomes HOLD at the same edge and the counter loads PC_HOLD_CYCLES.
  - pc_hold=1 for cycles N+1 through N+PC_HOLD_CYCLES. The counter decrements each cycle in HOLD.
  - When the counter equals 1, the next state is ARB, so the next grant can occur in cycle N+PC_HOLD_CYCLES+1.
  - If PC_HOLD_CYCLES=0, a PC write behaves like any other write.
- Simultaneous events:
  - Any number of requesters may target the same pw. Grant order defines write order, so the last granted write wins.
  - A requester targeting PC_REG while others are valid is still granted strictly by round-robin; PC writes get no special priority.
- Reset mid-operation:
  - During HOLD: the state returns to ARB, pc_hold=0, and we=0 at once. The in-flight write (if any) is dropped.
  - After reset deasserts, requester 0 has the highest priority.
- Width rules: no arithmetic on the payload, which passes through unmodified. last_grant never takes the value 3.

Test Plan:
- Reset check: assert reset while we=1 with no clock edge -> we, pw, lbidw, ofsw and pc_hold read 0 immediately, and last_grant=2.
- Single request: only req 1 valid with pw=5, lbid=12'h00A, ofs=16'h1234 -> req_ready=3'b010 in the same cycle. The next cycle shows we=1, pw=5, lbidw=00A, ofsw=1234, last_grant=1. The cycle after shows we=0.
- Fairness: all three valid continuously with pw=1/2/3 -> grant sequence 0,1,2,0,1,2. we=1 on every cycle after the first grant, and req_ready is never more than one-hot.
- PC hold: req 2 writes pw=3F in cycle N while req 0 stays valid with pw=7 -> cycle N+1 shows we=1, pw=3F, pc_hold=1. req_ready=0 in cycles N+1 and N+2. req 0 is granted in cycle N+3, and pw=7 appears in N+4.
- Back-to-back PC writes: req 0 and req 1 both target pw=3F -> req 0 is granted first. Exactly 2 hold cycles follow, then req 1 is granted, then 2 further hold cycles. Two we pulses in total.
- Reset during HOLD: assert reset in the first hold cycle -> pc_hold=0 and we=0 asynchronously. After release, with all three requesters valid, req 0 is granted first.

Source files
------------

// File: rtl/preg_write_arbiter.sv
// Round-robin arbiter sharing the pointer register file write port among three requesters,
// with a programmable hold window after any write to the PC pointer register.
module preg_write_arbiter #(
  parameter logic [5:0] PC_REG         = 6'h3f,
  parameter int         PC_HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [17:0] req_pw,
  input  logic [35:0] req_lbid,
  input  logic [47:0] req_ofs,
  output logic        we,
  output logic [5:0]  pw,
  output logic [11:0] lbidw,
  output logic [15:0] ofsw,
  output logic        pc_hold,
  output logic [1:0]  last_grant
);

  typedef enum logic {ARB, HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(PC_HOLD_CYCLES);

  state_t      r_state;
  logic [3:0]  r_holdCnt;
  logic        r_we;
  logic [5:0]  r_pw;
  logic [11:0] r_lbid;
  logic [15:0] r_ofs;
  logic [1:0]  r_lastGrant;

  logic [1:0]  w_p0, w_p1, w_p2;
  logic [1:0]  w_winner;
  logic        w_grant;
  logic [5:0]  w_winPw;
  logic [11:0] w_winLbid;
  logic [15:0] w_winOfs;
  logic        w_isPc;

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_p0     = nextIdx(r_lastGrant);
    w_p1     = nextIdx(w_p0);
    w_p2     = nextIdx(w_p1);
    w_winner = w_p0;
    w_grant  = 1'b0;
    if (r_state == ARB) begin
      if (req_valid[w_p0]) begin
        w_winner = w_p0;
        w_grant  = 1'b1;
      end else if (req_valid[w_p1]) begin
        w_winner = w_p1;
        w_grant  = 1'b1;
      end else if (req_valid[w_p2]) begin
        w_winner = w_p2;
        w_grant  = 1'b1;
      end
    end
  end

  always_comb begin
    w_winPw   = req_pw[5:0];
    w_winLbid = req_lbid[11:0];
    w_winOfs  = req_ofs[15:0];
    case (w_winner)
      2'd1: begin
        w_winPw   = req_pw[11:6];
        w_winLbid = req_lbid[23:12];
        w_winOfs  = req_ofs[31:16];
      end
      2'd2: begin
        w_winPw   = req_pw[17:12];
        w_winLbid = req_lbid[35:24];
        w_winOfs  = req_ofs[47:32];
      end
      default: ;
    endcase
  end

  assign w_isPc    = (w_winPw == PC_REG) && (PC_HOLD_CYCLES != 0);
  assign req_ready = w_grant ? (3'b001 << w_winner) : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB;
      r_holdCnt   <= 4'd0;
      r_we        <= 1'b0;
      r_pw        <= 6'd0;
      r_lbid      <= 12'd0;
      r_ofs       <= 16'd0;
      r_lastGrant <= 2'd2;
    end else begin
      r_we <= w_grant;
      if (w_grant) begin
        r_pw        <= w_winPw;
        r_lbid      <= w_winLbid;
        r_ofs       <= w_winOfs;
        r_lastGrant <= w_winner;
      end
      case (r_state)
        ARB: begin
          if (w_grant && w_isPc) begin
            r_state   <= HOLD;
            r_holdCnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          r_holdCnt <= r_holdCnt - 4'd1;
          if (r_holdCnt <= 4'd1) r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign we         = r_we;
  assign pw         = r_pw;
  assign lbidw      = r_lbid;
  assign ofsw       = r_ofs;
  assign pc_hold    = (r_state == HOLD);
  assign last_grant = r_lastGrant;

endmodule

// File: tb/tb_preg_write_arbiter.sv
// Directed bench for preg_write_arbiter: reset, single grant, fairness, PC hold windows,
// and reset during hold, with hand-computed expectations.
module tb_preg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [17:0] req_pw;
  logic [35:0] req_lbid;
  logic [47:0] req_ofs;
  logic        we;
  logic [5:0]  pw;
  logic [11:0] lbidw;
  logic [15:0] ofsw;
  logic        pc_hold;
  logic [1:0]  last_grant;

  int checks = 0;
  int errors = 0;
  int wePulses;

  preg_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pw     (req_pw),
    .req_lbid   (req_lbid),
    .req_ofs    (req_ofs),
    .we         (we),
    .pw         (pw),
    .lbidw      (lbidw),
    .ofsw       (ofsw),
    .pc_hold    (pc_hold),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 3'b000;
    req_pw    = '0;
    req_lbid  = '0;
    req_ofs   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_last", last_grant, 2);
    checkOutput("rst_hold", pc_hold, 0);
    reset = 1'b0;
    stepCycle();

    // Single request from requester 1
    req_valid = 3'b010;
    req_pw[11:6]    = 6'd5;
    req_lbid[23:12] = 12'h00A;
    req_ofs[31:16]  = 16'h1234;
    #1 checkOutput("single_ready", req_ready, 3'b010);
    stepCycle();
    checkOutput("single_we", we, 1);
    checkOutput("single_pw", pw, 5);
    checkOutput("single_lbid", lbidw, 12'h00A);
    checkOutput("single_ofs", ofsw, 16'h1234);
    checkOutput("single_last", last_grant, 1);
    req_valid = 3'b000;
    #1 checkOutput("idle_ready", req_ready, 0);
    stepCycle();
    checkOutput("single_we_low", we, 0);
    checkOutput("single_pw_hold", pw, 5);

    // Asynchronous reset while we=1
    req_valid = 3'b001;
    req_pw[5:0]    = 6'd9;
    req_lbid[11:0] = 12'hABC;
    req_ofs[15:0]  = 16'hBEEF;
    stepCycle();
    checkOutput("pre_rst_we", we, 1);
    checkOutput("pre_rst_ofs", ofsw, 16'hBEEF);
    req_valid = 3'b000;
    reset = 1'b1;
    #1;
    checkOutput("arst_we", we, 0);
    checkOutput("arst_pw", pw, 0);
    checkOutput("arst_lbid", lbidw, 0);
    checkOutput("arst_ofs", ofsw, 0);
    checkOutput("arst_hold", pc_hold, 0);
    checkOutput("arst_last", last_grant, 2);
    @(negedge clk);
    reset = 1'b0;
    stepCycle();

    // Fairness: all three valid, expect 0,1,2,0,1,2
    req_valid = 3'b111;
    req_pw    = {6'd3, 6'd2, 6'd1};
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput("fair_ready", req_ready, 32'(3'b001 << (i % 3)));
      stepCycle();
      checkOutput("fair_we", we, 1);
      checkOutput("fair_last", last_grant, i % 3);
      checkOutput("fair_pw", pw, (i % 3) + 1);
    end
    req_valid = 3'b000;
    stepCycle();

    // PC hold: get last_grant=1 so requester 2 wins over requester 0
    req_valid = 3'b010;
    req_pw    = {6'h3f, 6'd4, 6'd7};
    stepCycle();
    checkOutput("pc_setup_last", last_grant, 1);
    req_valid = 3'b101;
    #1 checkOutput("pc_n_ready", req_ready, 3'b100);
    stepCycle();
    req_valid = 3'b001;
    checkOutput("pc_n1_we", we, 1);
    checkOutput("pc_n1_pw", pw, 6'h3f);
    checkOutput("pc_n1_hold", pc_hold, 1);
    #1 checkOutput("pc_n1_ready", req_ready, 0);
    stepCycle();
    checkOutput("pc_n2_hold", pc_hold, 1);
    checkOutput("pc_n2_we", we, 0);
    #1 checkOutput("pc_n2_ready", req_ready, 0);
    stepCycle();
    checkOutput("pc_n3_hold", pc_hold, 0);
    #1 checkOutput("pc_n3_ready", req_ready, 3'b001);
    stepCycle();
    req_valid = 3'b000;
    checkOutput("pc_n4_we", we, 1);
    checkOutput("pc_n4_pw", pw, 7);
    checkOutput("pc_n4_last", last_grant, 0);
    stepCycle();

    // Back-to-back PC writes: first steer last_grant to 2
    req_valid = 3'b100;
    req_pw    = {6'd8, 6'h3f, 6'h3f};
    req_lbid  = {12'h000, 12'h002, 12'h001};
    stepCycle();
    checkOutput("b2b_setup_last", last_grant, 2);
    req_valid = 3'b011;
    #1 checkOutput("b2b_n_ready", req_ready, 3'b001);
    wePulses = 0;
    stepCycle();
    req_valid = 3'b010;
    if (we) wePulses++;
    checkOutput("b2b_n1_lbid", lbidw, 12'h001);
    checkOutput("b2b_n1_hold", pc_hold, 1);
    #1 checkOutput("b2b_n1_ready", req_ready, 0);
    stepCycle();
    if (we) wePulses++;
    checkOutput("b2b_n2_hold", pc_hold, 1);
    #1 checkOutput("b2b_n2_ready", req_ready, 0);
    stepCycle();
    if (we) wePulses++;
    checkOutput("b2b_n3_hold", pc_hold, 0);
    #1 checkOutput("b2b_n3_ready", req_ready, 3'b010);
    stepCycle();
    req_valid = 3'b000;
    if (we) wePulses++;
    checkOutput("b2b_n4_lbid", lbidw, 12'h002);
    checkOutput("b2b_n4_last", last_grant, 1);
    checkOutput("b2b_n4_hold", pc_hold, 1);
    stepCycle();
    if (we) wePulses++;
    checkOutput("b2b_n5_hold", pc_hold, 1);
    stepCycle();
    if (we) wePulses++;
    checkOutput("b2b_n6_hold", pc_hold, 0);
    checkOutput("b2b_we_pulses", wePulses, 2);

    // Reset during the first hold cycle
    req_valid = 3'b001;
    req_pw    = {6'd3, 6'd2, 6'h3f};
    #1 checkOutput("rh_ready", req_ready, 3'b001);
    stepCycle();
    req_valid = 3'b000;
    checkOutput("rh_hold_pre", pc_hold, 1);
    checkOutput("rh_we_pre", we, 1);
    reset = 1'b1;
    #1;
    checkOutput("rh_hold", pc_hold, 0);
    checkOutput("rh_we", we, 0);
    checkOutput("rh_last", last_grant, 2);
    @(negedge clk);
    reset = 1'b0;
    stepCycle();
    req_valid = 3'b111;
    req_pw    = {6'd3, 6'd2, 6'd1};
    #1 checkOutput("rh_post_ready", req_ready, 3'b001);
    stepCycle();
    req_valid = 3'b000;
    checkOutput("rh_post_last", last_grant, 0);
    checkOutput("rh_post_pw", pw, 1);
    checkOutput("rh_post_hold", pc_hold, 0);
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
